// File: rtl/vol_level_ctrl.sv
// rtl/vol_level_ctrl.sv - windowed peak detector with attack/decay smoothing and peak-hold marker
module vol_level_ctrl #(
   parameter int          WIN   = 2000,
   parameter logic [11:0] BASE  = 12'd2048,
   parameter int          SHIFT = 7,
   parameter int          DECAY = 2,
   parameter int          HOLD  = 5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        sample_valid,
   input  logic [11:0] mic_in,
   input  logic        freeze,
   output logic [3:0]  num,
   output logic [3:0]  peak_num,
   output logic        level_valid
);

   localparam int CW = (WIN > 2)   ? $clog2(WIN)    : 1;
   localparam int DW = (DECAY > 1) ? $clog2(DECAY)  : 1;
   localparam int HW = (HOLD > 0)  ? $clog2(HOLD+1) : 1;

   typedef enum logic [1:0] {ACC, MAP, UPD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [10:0]     wpeak_q, wpeak_d;
   logic [3:0]      new_lvl_q, new_lvl_d;
   logic [3:0]      num_q, num_d;
   logic [3:0]      peak_q, peak_d;
   logic [DW-1:0]   decay_q, decay_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            lv_q, lv_d;

   logic [11:0]     diff;
   logic [10:0]     amp;
   logic [10:0]     shifted;
   logic [3:0]      lvl;
   logic [3:0]      n_upd;

   // Amplitude above the DC midpoint, and the window peak mapped to a 0..15 level
   always_comb begin
      diff    = mic_in - BASE;
      amp     = '0;
      if (mic_in > BASE) begin
         // only reachable with a small BASE; clamp instead of wrapping
         amp = diff[11] ? 11'h7ff : diff[10:0];
      end
      shifted = wpeak_q >> SHIFT;
      lvl     = (shifted > 11'd15) ? 4'd15 : shifted[3:0];
   end

   // Window FSM plus attack/decay and peak-hold update rules
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wpeak_d   = wpeak_q;
      new_lvl_d = new_lvl_q;
      num_d     = num_q;
      peak_d    = peak_q;
      decay_d   = decay_q;
      hold_d    = hold_q;
      lv_d      = 1'b0;
      n_upd     = num_q;
      case (state_q)
         ACC: begin
            if (sample_valid) begin
               if (amp > wpeak_q) wpeak_d = amp;
               if (cnt_q == CW'(WIN-1)) begin
                  state_d = MAP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         MAP: begin
            new_lvl_d = lvl;
            state_d   = UPD;
         end
         UPD: begin
            wpeak_d = '0;
            cnt_d   = '0;
            state_d = ACC;
            if (!freeze) begin
               lv_d = 1'b1;
               if (new_lvl_q >= num_q) begin
                  n_upd   = new_lvl_q;
                  decay_d = '0;
               end else if (decay_q == DW'(DECAY-1)) begin
                  n_upd   = num_q - 1'b1;
                  decay_d = '0;
               end else begin
                  decay_d = decay_q + 1'b1;
               end
               num_d = n_upd;
               if (n_upd > peak_q) begin
                  peak_d = n_upd;
                  hold_d = '0;
               end else if (hold_q < HW'(HOLD)) begin
                  hold_d = hold_q + 1'b1;
               end else if (peak_q > n_upd) begin
                  peak_d = peak_q - 1'b1;
               end
            end
         end
         default: state_d = ACC;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ACC;
         cnt_q     <= '0;
         wpeak_q   <= '0;
         new_lvl_q <= '0;
         num_q     <= '0;
         peak_q    <= '0;
         decay_q   <= '0;
         hold_q    <= '0;
         lv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wpeak_q   <= wpeak_d;
         new_lvl_q <= new_lvl_d;
         num_q     <= num_d;
         peak_q    <= peak_d;
         decay_q   <= decay_d;
         hold_q    <= hold_d;
         lv_q      <= lv_d;
      end
   end

   assign num         = num_q;
   assign peak_num    = peak_q;
   assign level_valid = lv_q;

endmodule

// File: tb/tb_vol_level_ctrl.sv
// tb/tb_vol_level_ctrl.sv - directed table-driven bench for vol_level_ctrl
module tb_vol_level_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        sample_valid;
   logic [11:0] mic_in;
   logic        freeze;
   logic [3:0]  num;
   logic [3:0]  peak_num;
   logic        level_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0][11:0] s;
      logic             frz;
      logic             drop;
      logic             exp_lv;
      logic [3:0]       exp_num;
      logic [3:0]       exp_peak;
   } vec_t;

   vec_t tbl[13];

   vol_level_ctrl #(
      .WIN(4), .BASE(12'd2048), .SHIFT(7), .DECAY(2), .HOLD(1)
   ) dut (
      .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .mic_in(mic_in),
      .freeze(freeze), .num(num), .peak_num(peak_num), .level_valid(level_valid)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int idx, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c, input logic [11:0] d, input logic frz,
                          input logic drop, input logic lv, input logic [3:0] n,
                          input logic [3:0] p);
      tbl[idx].s[0]     = a;
      tbl[idx].s[1]     = b;
      tbl[idx].s[2]     = c;
      tbl[idx].s[3]     = d;
      tbl[idx].frz      = frz;
      tbl[idx].drop     = drop;
      tbl[idx].exp_lv   = lv;
      tbl[idx].exp_num  = n;
      tbl[idx].exp_peak = p;
   endtask

   // Called just after a posedge: present one sample for exactly one edge
   task automatic send(input logic [11:0] val);
      sample_valid = 1'b1;
      mic_in       = val;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   // Feed a 4-sample window with 4-cycle spacing and check the update pulse timing
   task automatic run_win(input vec_t v, input int idx);
      freeze = v.frz;
      for (int i = 0; i < 4; i++) begin
         send(v.s[i]);
         if (i < 3) begin
            repeat (3) begin
               @(posedge clk); #1;
               chk($sformatf("w%0d_gap_lv", idx), int'(level_valid), 0);
            end
         end
      end
      if (v.drop) begin
         sample_valid = 1'b1;
         mic_in       = 12'd4095;
      end
      @(posedge clk); #1;
      chk($sformatf("w%0d_e1_lv", idx), int'(level_valid), 0);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      chk($sformatf("w%0d_e2_lv", idx), int'(level_valid), int'(v.exp_lv));
      chk($sformatf("w%0d_num", idx), int'(num), int'(v.exp_num));
      chk($sformatf("w%0d_peak", idx), int'(peak_num), int'(v.exp_peak));
      @(posedge clk); #1;
      chk($sformatf("w%0d_e3_lv", idx), int'(level_valid), 0);
   endtask

   initial begin
      vec_t v;
      rstn         = 1'b0;
      sample_valid = 1'b0;
      mic_in       = 12'd0;
      freeze       = 1'b0;

      // attack, decay of num and marker, re-attack, freeze, dropped samples
      set_vec(0,  12'd2048, 12'd2300, 12'd4095, 12'd2100, 0, 0, 1, 15, 15);
      set_vec(1,  12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 1, 15, 15);
      set_vec(2,  12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 1, 14, 14);
      set_vec(3,  12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 1, 14, 14);
      set_vec(4,  12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 1, 13, 13);
      set_vec(5,  12'd2100, 12'd2688, 12'd2048, 12'd2000, 0, 0, 1, 13, 13);
      set_vec(6,  12'd2048, 12'd2500, 12'd3968, 12'd2048, 0, 0, 1, 15, 15);
      set_vec(7,  12'd2432, 12'd2048, 12'd2048, 12'd2048, 1, 0, 0, 15, 15);
      set_vec(8,  12'd2048, 12'd2432, 12'd2048, 12'd2048, 1, 0, 0, 15, 15);
      set_vec(9,  12'd2048, 12'd2048, 12'd2432, 12'd2048, 0, 0, 1, 15, 15);
      set_vec(10, 12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 1, 1, 14, 14);
      set_vec(11, 12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 1, 14, 14);
      set_vec(12, 12'd2048, 12'd2048, 12'd2048, 12'd2048, 0, 0, 1, 13, 13);

      // reset held over 3 edges with samples toggling
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         sample_valid = ~sample_valid;
         mic_in       = 12'd4095;
         @(posedge clk); #1;
         chk($sformatf("rst%0d_num", i), int'(num), 0);
         chk($sformatf("rst%0d_peak", i), int'(peak_num), 0);
         chk($sformatf("rst%0d_lv", i), int'(level_valid), 0);
      end
      sample_valid = 1'b0;
      rstn         = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 13; k++) begin
         run_win(tbl[k], k);
      end

      // reset after 2 loud samples discards the window and clears the levels
      send(12'd4095);
      repeat (3) @(posedge clk);
      #1;
      send(12'd4095);
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("midrst_num", int'(num), 0);
      chk("midrst_peak", int'(peak_num), 0);
      chk("midrst_lv", int'(level_valid), 0);
      rstn = 1'b1;
      @(posedge clk); #1;
      v.s[0] = 12'd2304; v.s[1] = 12'd2304; v.s[2] = 12'd2200; v.s[3] = 12'd2048;
      v.frz = 1'b0; v.drop = 1'b0; v.exp_lv = 1'b1; v.exp_num = 4'd2; v.exp_peak = 4'd2;
      run_win(v, 13);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
